// File: rtl/epm3032_ym2149x2_pkg.sv
// Shared constants for the dual-YM2149 (TurboSound) glue CPLD.
// Port decode works on the five address lines the CPLD sees, packed as
// {a15, a14, a2, a1, a0}. A port matches when (addr & MASK) == MATCH.
package epm3032_ym2149x2_pkg;

    // Frames longer than this (in cpu_clock cycles) mean a 7 MHz CPU.
    localparam int TURBO_THRESHOLD_DEF = 105000;
    localparam int CNT_W_DEF           = 18;

    // Either PSG port: a15=1, a1=0 (#FFFD and #BFFD).
    localparam logic [4:0] AY_MASK    = 5'b10010;
    localparam logic [4:0] AY_MATCH   = 5'b10000;
    // Register-select / read port #FFFD: a15=1, a14=1, a1=0.
    localparam logic [4:0] FFFD_MASK  = 5'b11010;
    localparam logic [4:0] FFFD_MATCH = 5'b11000;
    // Data write port #BFFD: a15=1, a14=0, a1=0.
    localparam logic [4:0] BFFD_MASK  = 5'b11010;
    localparam logic [4:0] BFFD_MATCH = 5'b10000;
    // ULA port #FE: a0=0.
    localparam logic [4:0] FE_MASK    = 5'b00001;
    localparam logic [4:0] FE_MATCH   = 5'b00000;
    // Covox port #FB: a2=0, a1=1, a0=1.
    localparam logic [4:0] FB_MASK    = 5'b00111;
    localparam logic [4:0] FB_MATCH   = 5'b00011;

    // High data nibble that marks a chip-select write to #FFFD.
    localparam logic [3:0] CHIP_SEL_NIBBLE = 4'hF;

    function automatic logic port_hit(input logic [4:0] addr,
                                      input logic [4:0] mask,
                                      input logic [4:0] match);
        return ((addr & mask) == match);
    endfunction

endpackage

// File: rtl/epm3032_ym2149x2_ym_clk_gen.sv
// PSG clock generator with automatic turbo compensation.
// Counts cpu_clock cycles per INT frame; a frame longer than TURBO_THRESHOLD
// marks a 7 MHz CPU and switches the divider from /2 to /4 so the PSG clock
// stays near 1.75 MHz.
// Ports:
//   clk      in   CPU clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   int_n    in   frame interrupt, active-low, asynchronous to nothing in particular
//   ym_clock out  PSG clock (registered)
module epm3032_ym2149x2_ym_clk_gen #(
    parameter int TURBO_THRESHOLD = 105000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic int_n,
    output logic ym_clock
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(TURBO_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             int_meta_r;
    logic             int_sync_r;
    logic             int_prev_r;
    logic             int_fall_s;
    logic [CNT_W-1:0] count_r;
    logic             turbo_r;
    logic             div_r;
    logic             mode_r;
    logic             ym_clk_r;
    logic             div_term_s;

    // Two-flop synchroniser for INT plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_r <= 1'b1;
            int_sync_r <= 1'b1;
            int_prev_r <= 1'b1;
        end else begin
            int_meta_r <= int_n;
            int_sync_r <= int_meta_r;
            int_prev_r <= int_sync_r;
        end
    end

    // Falling-edge detect and divider terminal count.
    always_comb begin
        int_fall_s = int_prev_r & ~int_sync_r;
        if (mode_r) begin
            div_term_s = div_r;
        end else begin
            div_term_s = 1'b1;
        end
    end

    // Frame-length counter; the INT edge takes priority over saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            turbo_r <= 1'b0;
        end else if (int_fall_s) begin
            count_r <= {CNT_W{1'b0}};
            turbo_r <= (count_r > THR_C);
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    // Divider: the mode is only sampled when the output toggles, so every
    // half-period is at least one full cpu_clock long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= 1'b0;
            mode_r   <= 1'b0;
            ym_clk_r <= 1'b0;
        end else if (div_term_s) begin
            div_r    <= 1'b0;
            mode_r   <= turbo_r;
            ym_clk_r <= ~ym_clk_r;
        end else begin
            div_r    <= 1'b1;
        end
    end

    assign ym_clock = ym_clk_r;

endmodule

// File: rtl/epm3032_ym2149x2.sv
// Glue logic for a dual-YM2149 (TurboSound) card on the ZX Spectrum bus.
// Decodes Z80 I/O cycles into BC1/BDIR, keeps the active-chip select,
// latches beeper/tape bits from port #FE, strobes an external Covox latch
// on #FB writes and drives IORQGE while the card answers a #FFFD read.
// Ports:
//   cpu_clock            in   Z80 clock, rising edge
//   reset                in   asynchronous active-low reset
//   a0,a1,a2,a14,a15     in   Z80 address bits
//   m1,iorq,rd,wr        in   Z80 control, active-low
//   dos                  in   low while TR-DOS ROM is paged (card disabled)
//   int_n                in   frame interrupt, active-low (the Z80 /INT pin;
//                             "int" itself is a reserved word)
//   d_0,d_4..d_7         in   Z80 data bits
//   bc1,bdir             out  PSG bus control, shared by both chips
//   ym_0,ym_1            out  chip selects, active-low, exactly one low
//   ym_clock             out  PSG clock
//   beeper,tapeout       out  latched #FE bits 4 and 5
//   covox                out  active-low Covox write strobe
//   ioge_c               out  IORQGE, high while the card drives a read
// bc1/bdir/covox/ioge_c are combinational so they follow the bus cycle and
// keep working while reset is held.
module epm3032_ym2149x2
    import epm3032_ym2149x2_pkg::*;
#(
    parameter int TURBO_THRESHOLD = TURBO_THRESHOLD_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic cpu_clock,
    input  logic reset,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a14,
    input  logic a15,
    input  logic m1,
    input  logic iorq,
    input  logic rd,
    input  logic wr,
    input  logic dos,
    input  logic int_n,
    input  logic d_0,
    input  logic d_4,
    input  logic d_5,
    input  logic d_6,
    input  logic d_7,
    output logic bc1,
    output logic bdir,
    output logic ym_0,
    output logic ym_1,
    output logic ym_clock,
    output logic beeper,
    output logic tapeout,
    output logic covox,
    output logic ioge_c
);

    logic [4:0] addr_s;
    logic       io_s;
    logic       ay_hit_s;
    logic       fffd_hit_s;
    logic       sel_wr_s;
    logic       fe_wr_s;
    logic       ym_sel_r;     // 0 = chip0 active, 1 = chip1 active
    logic       beeper_r;
    logic       tapeout_r;

    // I/O cycle decode; M1 low (interrupt acknowledge) and TR-DOS are excluded.
    always_comb begin
        addr_s     = {a15, a14, a2, a1, a0};
        io_s       = ~iorq & m1 & dos;
        ay_hit_s   = io_s & port_hit(addr_s, AY_MASK, AY_MATCH);
        fffd_hit_s = io_s & port_hit(addr_s, FFFD_MASK, FFFD_MATCH);
        bdir       = ay_hit_s & ~wr;
        bc1        = fffd_hit_s & (~wr | ~rd);
        ioge_c     = fffd_hit_s & ~rd;
        covox      = ~(io_s & ~wr & port_hit(addr_s, FB_MASK, FB_MATCH));
        // Register numbers >15 are ignored by the PSGs, so #Fx doubles as
        // the chip-select command without disturbing either chip.
        sel_wr_s   = fffd_hit_s & ~wr & ({d_7, d_6, d_5, d_4} == CHIP_SEL_NIBBLE);
        fe_wr_s    = io_s & ~wr & port_hit(addr_s, FE_MASK, FE_MATCH);
    end

    // Chip-select and #FE latches.
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            ym_sel_r  <= 1'b0;
            beeper_r  <= 1'b0;
            tapeout_r <= 1'b0;
        end else begin
            if (sel_wr_s) begin
                ym_sel_r <= ~d_0;
            end
            if (fe_wr_s) begin
                beeper_r  <= d_4;
                tapeout_r <= d_5;
            end
        end
    end

    assign ym_0    = ym_sel_r;
    assign ym_1    = ~ym_sel_r;
    assign beeper  = beeper_r;
    assign tapeout = tapeout_r;

    epm3032_ym2149x2_ym_clk_gen #(
        .TURBO_THRESHOLD (TURBO_THRESHOLD),
        .CNT_W           (CNT_W)
    ) u_ym_clk_gen (
        .clk      (cpu_clock),
        .rst_n    (reset),
        .int_n    (int_n),
        .ym_clock (ym_clock)
    );

endmodule

// File: tb/tb_epm3032_ym2149x2.sv
// Scoreboard bench for epm3032_ym2149x2. The driver issues bus cycles and
// frame-length scenarios, pushes the reference model's expectation into a
// queue, and a monitor process pops and compares on the falling clock edge.
// A short frame counter (CNT_W=8, threshold 105) keeps turbo runs brief.
module tb_epm3032_ym2149x2;

    localparam int THR   = 105;
    localparam int CW    = 8;
    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;

    logic clk = 1'b0;
    logic reset;
    logic a0, a1, a2, a14, a15;
    logic m1, iorq, rd, wr, dos, int_n;
    logic d_0, d_4, d_5, d_6, d_7;
    logic bc1, bdir, ym_0, ym_1, ym_clock, beeper, tapeout, covox, ioge_c;

    always #5 clk = ~clk;

    epm3032_ym2149x2 #(.TURBO_THRESHOLD(THR), .CNT_W(CW)) dut (
        .cpu_clock(clk), .reset(reset),
        .a0(a0), .a1(a1), .a2(a2), .a14(a14), .a15(a15),
        .m1(m1), .iorq(iorq), .rd(rd), .wr(wr), .dos(dos), .int_n(int_n),
        .d_0(d_0), .d_4(d_4), .d_5(d_5), .d_6(d_6), .d_7(d_7),
        .bc1(bc1), .bdir(bdir), .ym_0(ym_0), .ym_1(ym_1), .ym_clock(ym_clock),
        .beeper(beeper), .tapeout(tapeout), .covox(covox), .ioge_c(ioge_c)
    );

    typedef struct packed {
        int   kind;      // 0 = bus snapshot, 1 = PSG clock period
        logic bc1, bdir, ioge, covox, ym0, ym1, beep, tape;
        logic chk_ymclk, ymclk;
        int   period;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    int   push_cnt = 0, done_cnt = 0;

    // Reference model state: which chip is active and the #FE bits.
    int   m_chip = 0;
    logic m_beep = 1'b0, m_tape = 1'b0;

    // Frame generator and independent frame-length measurement.
    int frame_len = 70;
    int cyc = 0, last_fall = 0, last_len = 0, n_falls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int_n = 1'b1;
        forever begin
            repeat (frame_len - 4) @(posedge clk);
            #1 int_n = 1'b0;
            repeat (4) @(posedge clk);
            #1 int_n = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge int_n);
            last_len  = cyc - last_fall;
            last_fall = cyc;
            n_falls++;
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compares whatever the scoreboard holds on each falling edge.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.kind == 0) begin
                    chk("bc1", bc1, e.bc1);
                    chk("bdir", bdir, e.bdir);
                    chk("ioge_c", ioge_c, e.ioge);
                    chk("covox", covox, e.covox);
                    chk("ym_0", ym_0, e.ym0);
                    chk("ym_1", ym_1, e.ym1);
                    chk("beeper", beeper, e.beep);
                    chk("tapeout", tapeout, e.tape);
                    if (e.chk_ymclk) chk("ym_clock", ym_clock, e.ymclk);
                end else begin
                    logic prev;
                    int   seen, cnt, per;
                    prev = ym_clock; seen = 0; cnt = 0; per = -1;
                    for (int k = 0; k < 40 && per < 0; k++) begin
                        @(negedge clk);
                        if (!prev && ym_clock) begin
                            if (seen != 0) per = cnt;
                            seen = 1;
                            cnt  = 0;
                        end
                        cnt++;
                        prev = ym_clock;
                    end
                    tests++;
                    if (per != e.period) begin
                        fails++;
                        $display("FAIL ym_clock_period: got %0d cycles expected %0d (frame %0d)",
                                 per, e.period, last_len);
                    end
                end
                done_cnt++;
            end
        end
    end

    task automatic wait_done();
        int g = 0;
        while (done_cnt != push_cnt && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (done_cnt != push_cnt) begin
            tests++; fails++;
            $display("FAIL scoreboard_timeout: done %0d expected %0d", done_cnt, push_cnt);
            q.delete();
            done_cnt = push_cnt;
        end
    endtask

    task automatic push(input exp_t x);
        q.push_back(x);
        push_cnt++;
        wait_done();
    endtask

    // Port-level reference: what the card answers for one I/O cycle.
    function automatic exp_t model_bus(input logic [15:0] addr, input int op,
                                       input logic m1_pin, input logic dos_pin);
        exp_t x;
        logic io, fffd, bffd, w, r;
        w    = (op == OP_WR);
        r    = (op == OP_RD);
        io   = (op != OP_IDLE) && m1_pin && dos_pin;
        fffd = io && ((addr & 16'hC002) == 16'hC000);
        bffd = io && ((addr & 16'hC002) == 16'h8000);
        x           = '0;
        x.kind      = 0;
        x.bdir      = (fffd || bffd) && w;
        x.bc1       = fffd && (w || r);
        x.ioge      = fffd && r;
        x.covox     = !(io && w && (addr[2:0] == 3'b011));
        x.ym0       = (m_chip == 1);
        x.ym1       = (m_chip == 0);
        x.beep      = m_beep;
        x.tape      = m_tape;
        x.chk_ymclk = 1'b0;
        x.ymclk     = 1'b0;
        x.period    = 0;
        return x;
    endfunction

    task automatic model_commit(input logic [15:0] addr, input logic [7:0] data,
                                input int op, input logic m1_pin, input logic dos_pin);
        logic io;
        io = (op == OP_WR) && m1_pin && dos_pin;
        if (io && ((addr & 16'hC002) == 16'hC000) && (data[7:4] == 4'hF))
            m_chip = data[0] ? 0 : 1;
        if (io && !addr[0]) begin
            m_beep = data[4];
            m_tape = data[5];
        end
    endtask

    task automatic set_idle();
        iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; dos = 1'b1;
    endtask

    // One bus cycle: drive, check during the cycle, let the edge latch, go idle.
    task automatic bus(input logic [15:0] addr, input logic [7:0] data, input int op,
                       input logic m1_pin, input logic dos_pin);
        @(posedge clk); #1;
        {a15, a14, a2, a1, a0} = {addr[15], addr[14], addr[2], addr[1], addr[0]};
        {d_7, d_6, d_5, d_4, d_0} = {data[7], data[6], data[5], data[4], data[0]};
        iorq = (op == OP_IDLE); wr = (op != OP_WR); rd = (op != OP_RD);
        m1 = m1_pin; dos = dos_pin;
        push(model_bus(addr, op, m1_pin, dos_pin));
        if (reset) model_commit(addr, data, op, m1_pin, dos_pin);
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic idle_check();
        bus(16'h0000, 8'h00, OP_IDLE, 1'b1, 1'b1);
    endtask

    task automatic wait_falls(input int n);
        int start, g;
        start = n_falls; g = 0;
        while (n_falls < start + n && g < n * 400 + 50) begin
            @(posedge clk); g++;
        end
        if (n_falls < start + n) begin
            tests++; fails++;
            $display("FAIL int_timeout: saw %0d falls expected %0d", n_falls - start, n);
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic period_check();
        exp_t x;
        x = '0;
        x.kind   = 1;
        x.period = (last_len > THR) ? 4 : 2;
        @(posedge clk); #1;
        push(x);
    endtask

    task automatic reset_check();
        exp_t x;
        x = model_bus(16'h0000, OP_IDLE, 1'b1, 1'b1);
        x.chk_ymclk = 1'b1;
        x.ymclk     = 1'b0;
        push(x);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rdat;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rdat;
        int          op;
        reset = 1'b0;
        {a15, a14, a2, a1, a0} = 5'b00000;
        {d_7, d_6, d_5, d_4, d_0} = 5'b00000;
        set_idle();
        #2;
        reset_check();
        @(posedge clk); #1 reset = 1'b1;

        // Directed decode cases.
        bus(16'hBFFD, 8'h00, OP_WR, 1'b1, 1'b1);
        bus(16'hFFFD, 8'h07, OP_WR, 1'b1, 1'b1);
        bus(16'hFFFD, 8'h00, OP_RD, 1'b1, 1'b1);
        bus(16'h7FFD, 8'h00, OP_RD, 1'b1, 1'b1);
        bus(16'h7FFD, 8'h00, OP_WR, 1'b1, 1'b1);
        // Chip select, and blocked selects with M1 or DOS low.
        bus(16'hFFFD, 8'hFE, OP_WR, 1'b1, 1'b1);
        idle_check();
        bus(16'hFFFD, 8'hFF, OP_WR, 1'b0, 1'b1);
        bus(16'hFFFD, 8'hFF, OP_WR, 1'b1, 1'b0);
        idle_check();
        bus(16'hFFFD, 8'hFF, OP_WR, 1'b1, 1'b1);
        idle_check();
        // #FE latch and Covox strobe.
        bus(16'h00FE, 8'h10, OP_WR, 1'b1, 1'b1);
        idle_check();
        bus(16'h00FE, 8'h20, OP_WR, 1'b1, 1'b1);
        idle_check();
        bus(16'h00FB, 8'h55, OP_WR, 1'b1, 1'b1);
        idle_check();

        // Randomised bus traffic.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 16'hFFFD;
                1:       ra = 16'hBFFD;
                2:       ra = 16'h7FFD;
                3:       ra = 16'h00FE;
                4:       ra = 16'h00FB;
                default: ra = 16'($urandom);
            endcase
            rdat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rdat[7:4] = 4'hF;
            op = $urandom_range(0, 2);
            bus(ra, rdat, op, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0));
        end
        idle_check();

        // Turbo detection: normal, long, saturating and back to normal frames.
        wait_falls(2);
        period_check();
        frame_len = 140;
        wait_falls(3);
        period_check();
        frame_len = 300;
        wait_falls(3);
        period_check();
        frame_len = 70;
        wait_falls(3);
        period_check();

        // Reset asserted mid-cycle after making every latch non-zero.
        bus(16'h00FE, 8'h30, OP_WR, 1'b1, 1'b1);
        bus(16'hFFFD, 8'hF0, OP_WR, 1'b1, 1'b1);
        idle_check();
        @(posedge clk); #3 reset = 1'b0;
        m_chip = 0; m_beep = 1'b0; m_tape = 1'b0;
        reset_check();
        // Decode still answers while reset is held; latches stay cleared.
        bus(16'hFFFD, 8'hFE, OP_WR, 1'b1, 1'b1);
        reset_check();
        @(posedge clk); #1 reset = 1'b1;
        idle_check();
        wait_falls(2);
        period_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
